// File: rtl/id_pkg.sv
// Shared decode-stage types: opcodes, fetch entry and register-use record.
// decode_use() extracts which of rs1/rs2/rd an instruction really uses.
package id_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_I_LD    = 7'b0000011;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [6:0] OP_J       = 7'b1101111;
  localparam logic [6:0] OP_I_JAL   = 7'b1100111;
  localparam logic [6:0] OP_U_LD    = 7'b0110111;
  localparam logic [6:0] OP_U_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 use_rs1;
    logic                 use_rs2;
    logic                 wr_rd;
  } reg_use_t;

  function automatic reg_use_t decode_use(
    input logic [XLEN-1:0] inst
  );
    reg_use_t u;
    logic     r1;
    logic     r2;
    logic     wr;
    r1 = 1'b0;
    r2 = 1'b0;
    wr = 1'b0;
    unique case (1'b1)
      (inst[6:0] == OP_R):       begin r1 = 1'b1; r2 = 1'b1; wr = 1'b1; end
      (inst[6:0] == OP_I_ARITH): begin r1 = 1'b1; wr = 1'b1; end
      (inst[6:0] == OP_I_LD):    begin r1 = 1'b1; wr = 1'b1; end
      (inst[6:0] == OP_S):       begin r1 = 1'b1; r2 = 1'b1; end
      (inst[6:0] == OP_B):       begin r1 = 1'b1; r2 = 1'b1; end
      (inst[6:0] == OP_J):       wr = 1'b1;
      (inst[6:0] == OP_I_JAL):   begin r1 = 1'b1; wr = 1'b1; end
      (inst[6:0] == OP_U_LD):    wr = 1'b1;
      (inst[6:0] == OP_U_AUIPC): wr = 1'b1;
      default: ;
    endcase
    u.rs1     = inst[19:15];
    u.rs2     = inst[24:20];
    u.rd      = inst[11:7];
    // x0 is never a real source or destination
    u.use_rs1 = r1 && (u.rs1 != '0);
    u.use_rs2 = r2 && (u.rs2 != '0);
    u.wr_rd   = wr && (u.rd != '0);
    return u;
  endfunction

endpackage

// File: rtl/id_inst_fifo.sv
// Synchronous instruction FIFO with flush, occupancy count, full/empty.
// Ports: clk, rst (async low), push/din, pop/dout, flush, full, empty.
module id_inst_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  input  logic         flush,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // a slot freed by a same-cycle pop may be refilled
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/id_issue_scoreboard.sv
// Decode/issue stage: instruction FIFO, per-register pending-write counters
// and a registered issue slot. Optional `ID_WB_BYPASS_EN lets a retiring
// write satisfy a source in the same cycle. Ports: IF side in_*, EX side
// out_*, retire wb_*, flush, stall.
module id_issue_scoreboard
  import id_pkg::*;
#(
  parameter int INST_W     = 32,
  parameter int PC_W       = 32,
  parameter int NUM_REGS   = 32,
  parameter int IDX_W      = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [IDX_W-1:0]  out_rd,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_rd,
  input  logic              flush,
  output logic              stall
);

  localparam int ENT_W = INST_W + PC_W;
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  head;
  logic [INST_W-1:0] head_inst;
  logic [PC_W-1:0]   head_pc;
  logic              head_valid;
  logic              push;
  logic              load;
  reg_use_t          u;

  logic [CNT_W-1:0]  pend [NUM_REGS];
  logic [CNT_W-1:0]  p1;
  logic [CNT_W-1:0]  p2;
  logic [CNT_W-1:0]  pd;
  logic              byp1;
  logic              byp2;
  logic              rs1_hz;
  logic              rs2_hz;
  logic              rd_sat;
  logic              hazard;
  logic              inc;
  logic              dec;

  assign in_ready = !fifo_full && !flush;
  assign push     = in_valid && in_ready;

  id_inst_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({in_inst, in_pc}),
    .pop   (load),
    .dout  (head),
    .flush (flush),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_inst, head_pc} = head;
  assign head_valid = !fifo_empty;
  assign u  = decode_use(head_inst);
  assign p1 = pend[u.rs1];
  assign p2 = pend[u.rs2];
  assign pd = pend[u.rd];

`ifdef ID_WB_BYPASS_EN
  assign byp1 = wb_valid && (wb_rd == u.rs1) && (p1 == C_ONE);
  assign byp2 = wb_valid && (wb_rd == u.rs2) && (p2 == C_ONE);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // out_rd is 0 for non-writers and a used rs is never 0
  assign rs1_hz = u.use_rs1 &&
                  (((p1 != '0) && !byp1) ||
                   (out_valid && (out_rd == u.rs1)));
  assign rs2_hz = u.use_rs2 &&
                  (((p2 != '0) && !byp2) ||
                   (out_valid && (out_rd == u.rs2)));
  // the writer in the issue slot is not yet counted, so include it
  // to keep the counter from wrapping
  assign rd_sat = u.wr_rd &&
                  ((pd == C_MAX) ||
                   ((pd == C_MAX - C_ONE) && out_valid &&
                    (out_rd == u.rd)));
  assign hazard = rs1_hz || rs2_hz || rd_sat;
  assign stall  = head_valid && hazard;
  assign load   = head_valid && !hazard && !flush &&
                  (!out_valid || out_ready);

  // a flushed issue slot is dropped, not handed to EX
  assign inc = out_valid && out_ready && !flush && (out_rd != '0);
  assign dec = wb_valid && (wb_rd != '0) && (pend[wb_rd] != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc && (out_rd == IDX_W'(i)) &&
            !(dec && (wb_rd == IDX_W'(i))))
          pend[i] <= pend[i] + C_ONE;
        else if (dec && (wb_rd == IDX_W'(i)) &&
                 !(inc && (out_rd == IDX_W'(i))))
          pend[i] <= pend[i] - C_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
      out_rd    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_inst  <= head_inst;
      out_pc    <= head_pc;
      out_rd    <= u.wr_rd ? u.rd : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Bench for id_issue_scoreboard: decode table, directed hazard sequences,
// then random traffic against a queue-based reference model.
module tb_id_issue_scoreboard;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_issue_scoreboard dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_rd    (out_rd),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .stall     (stall)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op,
    input int rd, input int rs1, input int rs2);
    return {7'h0, 5'(rs2), 5'(rs1), 3'h0, 5'(rd), op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input int r);
    wb_valid = 1'b1;
    wb_rd    = 5'(r);
    step();
    wb_valid = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  bit          m_ov;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  int          m_rd;
  int          m_pend[32];

  function automatic bit m_r1(input logic [31:0] i);
    return i[6:0] inside {OP_R, OP_I_ARITH, OP_I_LD,
                          OP_S, OP_B, OP_I_JAL};
  endfunction
  function automatic bit m_r2(input logic [31:0] i);
    return i[6:0] inside {OP_R, OP_S, OP_B};
  endfunction
  function automatic int m_dst(input logic [31:0] i);
    if (i[6:0] inside {OP_R, OP_I_ARITH, OP_I_LD, OP_J,
                       OP_I_JAL, OP_U_LD, OP_U_AUIPC})
      return int'(i[11:7]);
    return 0;
  endfunction

  function automatic bit m_src_busy(input int rs);
    bit byp;
    if (rs == 0) return 1'b0;
    byp = 1'b0;
`ifdef ID_WB_BYPASS_EN
    byp = wb_valid && int'(wb_rd) == rs && m_pend[rs] == 1;
`endif
    if (m_pend[rs] > 0 && !byp) return 1'b1;
    return m_ov && m_rd == rs;
  endfunction

  function automatic bit m_blocked(input logic [31:0] i);
    int d;
    int outstanding;
    if (m_r1(i) && m_src_busy(int'(i[19:15]))) return 1'b1;
    if (m_r2(i) && m_src_busy(int'(i[24:20]))) return 1'b1;
    d = m_dst(i);
    if (d == 0) return 1'b0;
    outstanding = m_pend[d] + ((m_ov && m_rd == d) ? 1 : 0);
    return outstanding >= 3;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10];
    ops = '{OP_R, OP_I_ARITH, OP_I_LD, OP_S, OP_B, OP_J,
            OP_I_JAL, OP_U_LD, OP_U_AUIPC, 7'b1110011};
    return {7'($urandom), 5'($urandom_range(0, 5)),
            5'($urandom_range(0, 5)), 3'($urandom),
            5'($urandom_range(0, 5)), ops[$urandom_range(0, 9)]};
  endfunction

  // ---------------- decode table ----------------
  typedef struct {
    logic [31:0] inst;
    bit          stall;
    int          rd;
  } vec_t;

  vec_t vt[18];

  initial begin
    bit   e_rdy;
    bit   e_stl;
    bit   ld;
    bit   acc;
    int   np[32];
    int   cands[$];
    ent_t e;

    vt[0]  = '{mk(OP_I_ARITH, 5, 6, 7), 0, 5};
    vt[1]  = '{mk(OP_R, 5, 6, 7), 1, 0};
    vt[2]  = '{mk(OP_R, 5, 7, 6), 1, 0};
    vt[3]  = '{mk(OP_S, 5, 6, 7), 1, 0};
    vt[4]  = '{mk(OP_S, 5, 6, 1), 0, 0};
    vt[5]  = '{mk(OP_I_LD, 5, 7, 1), 1, 0};
    vt[6]  = '{mk(OP_I_LD, 5, 6, 7), 0, 5};
    vt[7]  = '{mk(OP_B, 9, 1, 7), 1, 0};
    vt[8]  = '{mk(OP_B, 9, 1, 2), 0, 0};
    vt[9]  = '{mk(OP_J, 1, 7, 7), 0, 1};
    vt[10] = '{mk(OP_I_JAL, 2, 7, 1), 1, 0};
    vt[11] = '{mk(OP_I_JAL, 2, 6, 7), 0, 2};
    vt[12] = '{mk(OP_U_LD, 3, 7, 7), 0, 3};
    vt[13] = '{mk(OP_U_AUIPC, 4, 7, 7), 0, 4};
    vt[14] = '{mk(OP_R, 0, 6, 1), 0, 0};
    vt[15] = '{mk(7'b1110011, 5, 7, 7), 0, 0};
    vt[16] = '{mk(OP_I_ARITH, 7, 6, 0), 0, 7};
    vt[17] = '{mk(OP_R, 0, 0, 7), 1, 0};

    rst = 1'b0; in_valid = 0; in_inst = '0; in_pc = '0;
    out_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
    #12 rst = 1'b1;
    step();

    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall, 0);

    // ADD x3 then dependent SUB x4,x3,x1
    out_ready = 1;
    in_valid = 1; in_inst = mk(OP_R, 3, 1, 2); in_pc = 32'h100;
    step();
    chk("add_lat1_valid", out_valid, 0);
    in_inst = mk(OP_R, 4, 3, 1); in_pc = 32'h104;
    step();
    chk("add_valid", out_valid, 1);
    chk("add_rd", out_rd, 3);
    chk("add_pc", out_pc, 32'h100);
    in_valid = 0;
    #1 chk("sub_stall_inflight", stall, 1);
    step();
    chk("sub_not_issued", out_valid, 0);
    chk("sub_stall_pend3", stall, 1);
    step(); step();
    chk("sub_still_stall", stall, 1);
    wb_valid = 1; wb_rd = 5'd3;
    #1;
`ifdef ID_WB_BYPASS_EN
    chk("sub_stall_bypass", stall, 0);
    step();
    wb_valid = 0;
    chk("sub_issue_bypass", out_valid, 1);
    chk("sub_rd_bypass", out_rd, 4);
`else
    chk("sub_stall_wbcycle", stall, 1);
    step();
    wb_valid = 0;
    chk("sub_wait_one", out_valid, 0);
    #1 chk("sub_stall_clear", stall, 0);
    step();
    chk("sub_issue", out_valid, 1);
    chk("sub_rd", out_rd, 4);
`endif
    step();
    wb(4);

    // two outstanding writers to x7, then the decode table
    in_valid = 1; in_inst = mk(OP_R, 7, 0, 0);
    step(); step();
    in_valid = 0;
    step(); step(); step();
    chk("x7_drained", out_valid, 0);
    out_ready = 0;
    foreach (vt[k]) begin
      flush = 1; step(); flush = 0;
      in_valid = 1; in_inst = vt[k].inst; in_pc = 32'(k);
      step();
      in_valid = 0;
      #1 chk($sformatf("tbl%0d_stall", k), stall, vt[k].stall);
      step();
      chk($sformatf("tbl%0d_valid", k), out_valid, !vt[k].stall);
      if (!vt[k].stall)
        chk($sformatf("tbl%0d_rd", k), out_rd, vt[k].rd);
    end
    flush = 1; step(); flush = 0;

    // fill FIFO behind a held issue slot, then flush
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_inst = mk(OP_I_ARITH, 10 + i, 0, 0);
      step();
    end
    in_valid = 0;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_out_rd", out_rd, 10);
    #1 chk("full_no_stall", stall, 0);
    flush = 1;
    #1 chk("flush_in_ready", in_ready, 0);
    step();
    flush = 0;
    chk("flush_out_valid", out_valid, 0);
    #1 chk("flush_in_ready_after", in_ready, 1);
    chk("flush_stall", stall, 0);
    in_valid = 1; in_inst = mk(OP_R, 12, 7, 0);
    step();
    in_valid = 0;
    #1 chk("flush_pend_kept", stall, 1);
    wb(7); wb(7);
    step(); step();
    chk("x7_release_valid", out_valid, 1);
    chk("x7_release_rd", out_rd, 12);
    flush = 1; step(); flush = 0;

    // four writers to x8 saturate the counter
    out_ready = 1;
    in_valid = 1; in_inst = mk(OP_I_ARITH, 8, 0, 0);
    repeat (4) step();
    in_valid = 0;
    repeat (6) step();
    chk("sat_stall", stall, 1);
    chk("sat_no_issue", out_valid, 0);
    wb(8);
    chk("sat_wait", out_valid, 0);
    step();
    chk("sat_release", out_valid, 1);
    chk("sat_release_rd", out_rd, 8);
    step();
    wb(8); wb(8); wb(8);

    // handshake and retire of x9 in the same cycle
    in_valid = 1; in_inst = mk(OP_R, 9, 0, 0);
    step();
    in_valid = 0;
    step(); step();
    out_ready = 0;
    in_valid = 1;
    step();
    in_valid = 0;
    step();
    chk("x9_second_valid", out_valid, 1);
    out_ready = 1; wb_valid = 1; wb_rd = 5'd9;
    step();
    wb_valid = 0; out_ready = 0;
    in_valid = 1; in_inst = mk(OP_R, 13, 9, 0);
    step();
    in_valid = 0;
    #1 chk("x9_pend_one", stall, 1);
    step();
    chk("x9_held", out_valid, 0);
    wb(9);
    step();
    chk("x9_release", out_valid, 1);
    chk("x9_release_rd", out_rd, 13);

    // asynchronous reset mid-stream
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_inst", out_inst, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_stall", stall, 0);
    chk("arst_in_ready", in_ready, 1);
    #3 rst = 1'b1;
    step();

    // random traffic against the model
    m_ov = 0; m_rd = 0;
    foreach (m_pend[r]) m_pend[r] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = rand_inst();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cands.delete();
      for (int r = 1; r < 32; r++)
        if (m_pend[r] > 0) cands.push_back(r);
      wb_valid = 0;
      wb_rd    = 5'($urandom);
      if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid = 1;
        wb_rd = 5'(cands[$urandom_range(0, cands.size() - 1)]);
      end else if ($urandom_range(0, 9) == 0) begin
        wb_valid = 1; wb_rd = 5'd0;
      end
      #1;
      e_rdy = (mq.size() < 4) && !flush;
      e_stl = (mq.size() > 0) && m_blocked(mq[0].inst);
      chk("rnd_in_ready", in_ready, e_rdy);
      chk("rnd_stall", stall, e_stl);
      chk("rnd_out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("rnd_out_inst", out_inst, m_inst);
        chk("rnd_out_pc", out_pc, m_pc);
        chk("rnd_out_rd", out_rd, m_rd);
      end
      acc = m_ov && out_ready && !flush;
      ld  = !flush && !e_stl && (mq.size() > 0) &&
            (!m_ov || out_ready);
      np = m_pend;
      if (acc && m_rd != 0) np[m_rd]++;
      if (wb_valid && wb_rd != 0 && m_pend[wb_rd] > 0)
        np[wb_rd]--;
      if (flush) begin
        mq.delete();
        m_ov = 0;
      end else begin
        if (ld) begin
          e = mq.pop_front();
          m_ov = 1; m_inst = e.inst; m_pc = e.pc;
          m_rd = m_dst(e.inst);
        end else if (out_ready) begin
          m_ov = 0;
        end
        if (in_valid && e_rdy)
          mq.push_back('{in_inst, in_pc});
      end
      m_pend = np;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
